seq_divider: RTL and testbench

//  Multi-cycle unsigned restoring divider for the ALU datapath.

---
 rtl/seq_divider.sv | 119 +++++++++++
 tb/tb_seq_divider.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock,
// start/done handshake, quotient/remainder plus dbz and Z flags.
module seq_divider #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic             Z
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_count;
  logic             r_dbz;
  logic             r_z;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_quo_shift;

  assign w_accept = start && (r_state != S_BUSY);
  assign w_last   = (r_count == CW'(1));

  // The shifted partial remainder can reach 2*divisor-1, so the trial
  // compare is WIDTH+1 bits; the difference itself always fits in WIDTH.
  assign w_trial     = {r_rem, r_quo[WIDTH-1]};
  assign w_ge        = (w_trial >= {1'b0, r_div});
  assign w_sub       = w_trial[WIDTH-1:0] - r_div;
  assign w_quo_shift = {r_quo[WIDTH-2:0], w_ge};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          w_state_next = (divisor == '0) ? S_DONE : S_BUSY;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_BUSY: begin
        if (w_last) w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_count <= '0;
      r_dbz   <= 1'b0;
      r_z     <= 1'b0;
    end else if (w_accept) begin
      if (divisor == '0) begin
        r_quo   <= '1;
        r_rem   <= dividend;
        r_div   <= '0;
        r_count <= '0;
        r_dbz   <= 1'b1;
        r_z     <= 1'b0;
      end else begin
        // r_quo starts as the dividend and fills with quotient bits from the right
        r_quo   <= dividend;
        r_rem   <= '0;
        r_div   <= divisor;
        r_count <= CW'(WIDTH);
      end
    end else if (r_state == S_BUSY) begin
      r_rem   <= w_ge ? w_sub : w_trial[WIDTH-1:0];
      r_quo   <= w_quo_shift;
      r_count <= r_count - CW'(1);
      if (w_last) begin
        r_dbz <= 1'b0;
        r_z   <= (w_quo_shift == '0);
      end
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign busy      = (r_state == S_BUSY);
  assign done      = (r_state == S_DONE);
  assign dbz       = r_dbz;
  assign Z         = r_z;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks for seq_divider (WIDTH=24): latency,
// results, flags, start handling while busy, back-to-back and reset abort.
module tb_seq_divider;

  localparam int W = 24;
  localparam logic [W-1:0] ALL1 = '1;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         dbz;
  logic         Z;

  int checks;
  int errors;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done),
    .dbz(dbz),
    .Z(Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands with start high for one edge; returns in cycle T+1.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // n = cycle index (T+n) at which done is seen; 100 means it never came.
  task automatic wait_done(output int n, output int busy_cnt);
    n = 1;
    busy_cnt = 0;
    while (!done && n < 100) begin
      if (busy) busy_cnt++;
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
    checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_q got %h want 0", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_r got %h want 0", remainder); end
    checks++; if (dbz !== 1'b0 || Z !== 1'b0) begin errors++; $display("FAIL reset_flags got dbz=%0b Z=%0b want 0 0", dbz, Z); end
    rst = 1'b0;
    tick();
    $display("reset: busy=%0b done=%0b q=%h r=%h", busy, done, quotient, remainder);
  endtask

  task automatic test_basic();
    int n, bc;
    start_op(24'd100, 24'd7);
    wait_done(n, bc);
    $display("100/7: done at T+%0d busy_cycles=%0d q=%0d r=%0d Z=%0b dbz=%0b", n, bc, quotient, remainder, Z, dbz);
    checks++; if (n !== 25) begin errors++; $display("FAIL basic_latency got T+%0d want T+25", n); end
    checks++; if (bc !== 24) begin errors++; $display("FAIL basic_busy_cycles got %0d want 24", bc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %0b want 0", busy); end
    checks++; if (quotient !== 24'd14) begin errors++; $display("FAIL basic_q got %0d want 14", quotient); end
    checks++; if (remainder !== 24'd2) begin errors++; $display("FAIL basic_r got %0d want 2", remainder); end
    checks++; if (Z !== 1'b0 || dbz !== 1'b0) begin errors++; $display("FAIL basic_flags got Z=%0b dbz=%0b want 0 0", Z, dbz); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %0b want 0", done); end
    checks++; if (quotient !== 24'd14 || remainder !== 24'd2) begin errors++; $display("FAIL basic_hold got %0d r %0d want 14 r 2", quotient, remainder); end
  endtask

  task automatic test_extremes();
    int n, bc;
    start_op(24'hFFFFFF, 24'd1);
    wait_done(n, bc);
    $display("FFFFFF/1: q=%h r=%h Z=%0b", quotient, remainder, Z);
    checks++; if (quotient !== 24'hFFFFFF || remainder !== 24'd0) begin errors++; $display("FAIL max_div1 got %h r %h want ffffff r 0", quotient, remainder); end
    checks++; if (Z !== 1'b0) begin errors++; $display("FAIL max_div1_Z got %0b want 0", Z); end
    tick();
    start_op(24'd3, 24'd5);
    wait_done(n, bc);
    $display("3/5: q=%0d r=%0d Z=%0b dbz=%0b", quotient, remainder, Z, dbz);
    checks++; if (quotient !== 24'd0 || remainder !== 24'd3) begin errors++; $display("FAIL small_quot got %0d r %0d want 0 r 3", quotient, remainder); end
    checks++; if (Z !== 1'b1 || dbz !== 1'b0) begin errors++; $display("FAIL small_quot_flags got Z=%0b dbz=%0b want 1 0", Z, dbz); end
    tick();
  endtask

  task automatic test_dbz();
    int n, bc;
    start_op(24'd5, 24'd0);
    wait_done(n, bc);
    $display("5/0: done at T+%0d busy_cycles=%0d q=%h r=%0d dbz=%0b Z=%0b", n, bc, quotient, remainder, dbz, Z);
    checks++; if (n !== 1) begin errors++; $display("FAIL dbz_latency got T+%0d want T+1", n); end
    checks++; if (bc !== 0) begin errors++; $display("FAIL dbz_busy got %0d want 0", bc); end
    checks++; if (quotient !== ALL1 || remainder !== 24'd5) begin errors++; $display("FAIL dbz_result got %h r %0d want ffffff r 5", quotient, remainder); end
    checks++; if (dbz !== 1'b1 || Z !== 1'b0) begin errors++; $display("FAIL dbz_flags got dbz=%0b Z=%0b want 1 0", dbz, Z); end
    tick();
    checks++; if (dbz !== 1'b1) begin errors++; $display("FAIL dbz_hold got %0b want 1", dbz); end
    start_op(24'd8, 24'd2);
    wait_done(n, bc);
    $display("8/2 after dbz: q=%0d r=%0d dbz=%0b", quotient, remainder, dbz);
    checks++; if (quotient !== 24'd4 || remainder !== 24'd0 || dbz !== 1'b0) begin errors++; $display("FAIL dbz_clear got %0d r %0d dbz=%0b want 4 r 0 dbz=0", quotient, remainder, dbz); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n, bc;
    start_op(24'd100, 24'd7);
    repeat (4) tick();
    // Now in cycle T+5: this start must be ignored.
    dividend = 24'd9;
    divisor  = 24'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n, bc);
    $display("100/7 with ignored start: done at T+%0d q=%0d r=%0d", n + 5, quotient, remainder);
    checks++; if (n !== 20) begin errors++; $display("FAIL ignore_latency got T+%0d want T+25", n + 5); end
    checks++; if (quotient !== 24'd14 || remainder !== 24'd2) begin errors++; $display("FAIL ignore_result got %0d r %0d want 14 r 2", quotient, remainder); end
    // Accept the next op in the DONE cycle.
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy got %0b want 1", busy); end
    wait_done(n, bc);
    $display("9/3 back-to-back: done at T+%0d q=%0d r=%0d", n + 25, quotient, remainder);
    checks++; if (n !== 25) begin errors++; $display("FAIL b2b_latency got T+%0d want T+50", n + 25); end
    checks++; if (quotient !== 24'd3 || remainder !== 24'd0) begin errors++; $display("FAIL b2b_result got %0d r %0d want 3 r 0", quotient, remainder); end
    tick();
  endtask

  task automatic test_reset_abort();
    int n, bc, dones;
    start_op(24'd100, 24'd7);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("abort: busy=%0b done=%0b q=%h r=%h dbz=%0b Z=%0b", busy, done, quotient, remainder, dbz, Z);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_ctrl got busy=%0b done=%0b want 0 0", busy, done); end
    checks++; if (quotient !== '0 || remainder !== '0) begin errors++; $display("FAIL abort_data got %h r %h want 0 r 0", quotient, remainder); end
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) dones++;
      tick();
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses want 0", dones); end
    start_op(24'd50, 24'd5);
    wait_done(n, bc);
    $display("50/5 after abort: done at T+%0d q=%0d r=%0d", n, quotient, remainder);
    checks++; if (n !== 25 || quotient !== 24'd10 || remainder !== 24'd0) begin errors++; $display("FAIL abort_recover got T+%0d %0d r %0d want T+25 10 r 0", n, quotient, remainder); end
    tick();
  endtask

  task automatic test_random();
    int n, bc, bad;
    logic [W-1:0] a, b;
    logic [2*W-1:0] prod;
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1, 2:    b = W'($urandom_range(1, 255));
        3:       b = a;
        default: b = W'($urandom);
      endcase
      start_op(a, b);
      wait_done(n, bc);
      prod = {{W{1'b0}}, quotient} * {{W{1'b0}}, b} + {{W{1'b0}}, remainder};
      checks++;
      if (n >= 100) begin
        errors++; bad++;
        $display("FAIL rand_timeout %h/%h got no done want done", a, b);
      end else if (b == '0) begin
        if (quotient !== ALL1 || remainder !== a || dbz !== 1'b1) begin
          errors++; bad++;
          $display("FAIL rand_dbz %h/0 got %h r %h dbz=%0b want ffffff r %h dbz=1", a, quotient, remainder, dbz, a);
        end
      end else if (prod !== {{W{1'b0}}, a} || remainder >= b || dbz !== 1'b0 || Z !== (quotient == '0)) begin
        errors++; bad++;
        $display("FAIL rand_div %h/%h got q=%h r=%h dbz=%0b Z=%0b want q*d+r=dividend, r<d", a, b, quotient, remainder, dbz, Z);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
        errors++; bad++;
        $display("FAIL rand_single_done %h/%h got done=%0b want 0", a, b, done);
      end
    end
    $display("random: 600 ops, %0d bad", bad);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    test_reset();
    test_basic();
    test_extremes();
    test_dbz();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
